// File: rtl/flag_seq_pkg.sv
// Shared types, widths and step arithmetic for the flag selector control path.
package flag_seq_pkg;

  localparam int SEL_W = 7;

  typedef logic [1:0] btn_state_t;
  localparam btn_state_t IDLE   = 2'd0;
  localparam btn_state_t DELAY  = 2'd1;
  localparam btn_state_t REPEAT = 2'd2;

  typedef enum logic [1:0] {
    STEP_NONE,
    STEP_NEXT,
    STEP_PREV,
    STEP_LOAD
  } step_t;

  // Counter width for a modulo-n frame counter, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [SEL_W-1:0] step_next(input logic [SEL_W-1:0] cur,
                                                 input logic [SEL_W-1:0] lim);
    return (cur >= lim) ? '0 : cur + 1'b1;
  endfunction

  function automatic logic [SEL_W-1:0] step_prev(input logic [SEL_W-1:0] cur,
                                                 input logic [SEL_W-1:0] lim);
    return ((cur == '0) || (cur > lim)) ? lim : cur - 1'b1;
  endfunction

endpackage

// File: rtl/flag_btn_repeat.sv
// One push-button: 2-flop synchroniser, frame-sampled debounce and hold/auto-repeat FSM.
module flag_btn_repeat
  import flag_seq_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_RATE     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_frame_tick,
  input  logic       i_btn,
  output logic       o_step_req,
  output logic       o_active,
  output btn_state_t o_state
);

  localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int DB_W     = cnt_w(DEBOUNCE_FRAMES);
  localparam int HD_W     = cnt_w(HOLD_MAX);
  localparam logic [DB_W-1:0] DB_LAST  = DB_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [HD_W-1:0] DLY_LAST = HD_W'(REPEAT_DELAY - 1);
  localparam logic [HD_W-1:0] RPT_LAST = HD_W'(REPEAT_RATE - 1);

  logic [1:0]      r_sync;
  logic            r_level;
  logic [DB_W-1:0] r_dcnt;
  btn_state_t      r_state;
  logic [HD_W-1:0] r_hold;

  logic            w_sample;
  logic            w_flip;
  logic            w_rise;
  logic            w_fall;
  btn_state_t      w_state_nxt;
  logic [HD_W-1:0] w_hold_nxt;
  logic            w_req;

  assign w_sample = r_sync[1];
  assign w_flip   = i_frame_tick && (w_sample != r_level) && (r_dcnt == DB_LAST);
  assign w_rise   = w_flip && !r_level;
  assign w_fall   = w_flip && r_level;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_level <= 1'b0;
      r_dcnt  <= '0;
    end else begin
      r_sync <= {r_sync[0], i_btn};
      if (i_frame_tick) begin
        if (w_sample == r_level) begin
          r_dcnt <= '0;
        end else if (r_dcnt == DB_LAST) begin
          r_level <= w_sample;
          r_dcnt  <= '0;
        end else begin
          r_dcnt <= r_dcnt + 1'b1;
        end
      end
    end
  end

  // A debounced release always wins over a repeat falling due on the same frame.
  always_comb begin
    w_state_nxt = r_state;
    w_hold_nxt  = r_hold;
    w_req       = 1'b0;
    if (i_frame_tick) begin
      if (w_fall) begin
        w_state_nxt = IDLE;
        w_hold_nxt  = '0;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_rise) begin
              w_req       = 1'b1;
              w_hold_nxt  = '0;
              w_state_nxt = DELAY;
            end
          end
          DELAY: begin
            if (r_hold == DLY_LAST) begin
              w_req       = 1'b1;
              w_hold_nxt  = '0;
              w_state_nxt = REPEAT;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
          REPEAT: begin
            if (r_hold == RPT_LAST) begin
              w_req      = 1'b1;
              w_hold_nxt = '0;
            end else begin
              w_hold_nxt = r_hold + 1'b1;
            end
          end
          default: begin
            w_state_nxt = IDLE;
            w_hold_nxt  = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  assign o_step_req = w_req;
  assign o_active   = (r_state != IDLE);
  assign o_state    = r_state;

endmodule

// File: rtl/flag_sequencer.sv
// Frame-synchronous flag selector: two repeating buttons, auto-cycle and direct load, wrapped at max.
module flag_sequencer
  import flag_seq_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 2,
  parameter int REPEAT_DELAY    = 30,
  parameter int REPEAT_RATE     = 8,
  parameter int AUTO_FRAMES     = 300
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             frame_tick,
  input  logic             btn_next,
  input  logic             btn_prev,
  input  logic             auto_en,
  input  logic             ld_en,
  input  logic [SEL_W-1:0] ld_value,
  input  logic [SEL_W-1:0] max,
  output logic [SEL_W-1:0] selector,
  output logic             changed
);

  localparam int AU_W = cnt_w(AUTO_FRAMES);
  localparam logic [AU_W-1:0] AUTO_LAST = AU_W'(AUTO_FRAMES - 1);

  logic [1:0]       r_auto_sync;
  logic [AU_W-1:0]  r_auto_cnt;
  logic [SEL_W-1:0] r_selector;
  logic             r_changed;

  logic             w_next_req;
  logic             w_prev_req;
  logic             w_next_active;
  logic             w_prev_active;
  btn_state_t       w_next_state;
  btn_state_t       w_prev_state;
  logic             w_any_active;
  logic             w_auto_fire;
  step_t            w_step;
  logic [SEL_W-1:0] w_sel_nxt;

  flag_btn_repeat #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_next (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_tick(frame_tick),
    .i_btn       (btn_next),
    .o_step_req  (w_next_req),
    .o_active    (w_next_active),
    .o_state     (w_next_state)
  );

  flag_btn_repeat #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES),
    .REPEAT_DELAY   (REPEAT_DELAY),
    .REPEAT_RATE    (REPEAT_RATE)
  ) u_prev (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_frame_tick(frame_tick),
    .i_btn       (btn_prev),
    .o_step_req  (w_prev_req),
    .o_active    (w_prev_active),
    .o_state     (w_prev_state)
  );

  assign w_any_active = w_next_active || w_prev_active;
  assign w_auto_fire  = frame_tick && r_auto_sync[1] && !w_any_active &&
                        (r_auto_cnt == AUTO_LAST);

  // ld_en is a level strobe held by the requester until it sees a frame_tick;
  // it is only acted on in the frame_tick cycle and then outranks every step.
  always_comb begin
    w_step = STEP_NONE;
    if (frame_tick) begin
      if (ld_en)                          w_step = STEP_LOAD;
      else if (w_next_req && w_prev_req)  w_step = STEP_NONE;
      else if (w_next_req)                w_step = STEP_NEXT;
      else if (w_prev_req)                w_step = STEP_PREV;
      else if (w_auto_fire)               w_step = STEP_NEXT;
    end
  end

  always_comb begin
    w_sel_nxt = r_selector;
    case (w_step)
      STEP_LOAD: w_sel_nxt = (ld_value > max) ? max : ld_value;
      STEP_NEXT: w_sel_nxt = step_next(r_selector, max);
      STEP_PREV: w_sel_nxt = step_prev(r_selector, max);
      default:   w_sel_nxt = r_selector;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_auto_sync <= '0;
      r_auto_cnt  <= '0;
    end else begin
      r_auto_sync <= {r_auto_sync[0], auto_en};
      if (frame_tick) begin
        if (!r_auto_sync[1] || w_any_active || (w_step != STEP_NONE) ||
            w_next_req || w_prev_req) begin
          r_auto_cnt <= '0;
        end else begin
          r_auto_cnt <= r_auto_cnt + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_selector <= '0;
      r_changed  <= 1'b0;
    end else begin
      r_selector <= w_sel_nxt;
      r_changed  <= (w_step != STEP_NONE) && (w_sel_nxt != r_selector);
    end
  end

  a_active_matches_state: assert property (@(posedge clk) disable iff (!rst_n)
    (w_next_active == (w_next_state != IDLE)) && (w_prev_active == (w_prev_state != IDLE)));

  assign selector = r_selector;
  assign changed  = r_changed;

endmodule

// File: tb/tb_flag_sequencer.sv
// Self-checking bench for flag_sequencer: directed scenarios plus random stimulus against a frame-level model.
module tb_flag_sequencer;

  localparam int DB = 2;
  localparam int RD = 4;
  localparam int RR = 2;
  localparam int AF = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       btn_next = 1'b0;
  logic       btn_prev = 1'b0;
  logic       auto_en = 1'b0;
  logic       ld_en = 1'b0;
  logic [6:0] ld_value = 7'd0;
  logic [6:0] max = 7'd85;
  logic [6:0] selector;
  logic       changed;

  int n_vec   = 0;
  int n_bad   = 0;
  int n_pulse = 0;

  // model state: debounced level, consecutive disagreeing samples, frames held since rise
  logic       lvl [2];
  int         dcnt[2];
  int         hold[2];
  logic       s1  [3];
  logic       s2  [3];
  int         a_cnt;
  logic [6:0] m_sel;
  logic       m_chg;

  always #5 clk = ~clk;

  flag_sequencer #(
    .DEBOUNCE_FRAMES(DB),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .AUTO_FRAMES    (AF)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .frame_tick(frame_tick),
    .btn_next  (btn_next),
    .btn_prev  (btn_prev),
    .auto_en   (auto_en),
    .ld_en     (ld_en),
    .ld_value  (ld_value),
    .max       (max),
    .selector  (selector),
    .changed   (changed)
  );

  function automatic logic [6:0] m_next(input logic [6:0] s);
    int v;
    v = s;
    if (v >= int'(max)) return 7'd0;
    return 7'(v + 1);
  endfunction

  function automatic logic [6:0] m_prev(input logic [6:0] s);
    int v;
    v = s;
    if (v == 0 || v > int'(max)) return max;
    return 7'(v - 1);
  endfunction

  // Returns 1 when this frame produces a step for button b.
  function automatic logic btn_frame(input int b, input logic smp);
    logic rose;
    rose = 1'b0;
    if (smp != lvl[b]) dcnt[b] = dcnt[b] + 1;
    else dcnt[b] = 0;
    if (dcnt[b] == DB) begin
      lvl[b]  = smp;
      dcnt[b] = 0;
      rose    = smp;
    end
    if (rose) begin
      hold[b] = 0;
      return 1'b1;
    end
    if (!lvl[b]) return 1'b0;
    hold[b] = hold[b] + 1;
    return (hold[b] >= RD) && (((hold[b] - RD) % RR) == 0);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      lvl[i] = 1'b0; dcnt[i] = 0; hold[i] = 0;
    end
    for (int i = 0; i < 3; i++) begin
      s1[i] = 1'b0; s2[i] = 1'b0;
    end
    a_cnt = 0;
    m_sel = 7'd0;
    m_chg = 1'b0;
  endtask

  task automatic model_clock();
    logic rn, rp, ar, busy;
    logic [6:0] nv;
    m_chg = 1'b0;
    if (frame_tick) begin
      busy = lvl[0] || lvl[1];
      rn = btn_frame(0, s2[0]);
      rp = btn_frame(1, s2[1]);
      ar = 1'b0;
      if (!s2[2] || busy || ld_en || rn || rp) begin
        a_cnt = 0;
      end else begin
        a_cnt = a_cnt + 1;
        if (a_cnt == AF) begin
          ar = 1'b1;
          a_cnt = 0;
        end
      end
      nv = m_sel;
      if (ld_en)           nv = (ld_value > max) ? max : ld_value;
      else if (rn && rp)   nv = m_sel;
      else if (rn)         nv = m_next(m_sel);
      else if (rp)         nv = m_prev(m_sel);
      else if (ar)         nv = m_next(m_sel);
      m_chg = (nv != m_sel);
      m_sel = nv;
    end
    s2[0] = s1[0]; s2[1] = s1[1]; s2[2] = s1[2];
    s1[0] = btn_next; s1[1] = btn_prev; s1[2] = auto_en;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_clock();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      n_vec++;
      if (selector !== m_sel || changed !== m_chg) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t: selector=%0d changed=%0b, model wants selector=%0d changed=%0b",
                 $time, selector, changed, m_sel, m_chg);
      end
      if (changed === 1'b1) n_pulse++;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One frame: three quiet cycles, then a one-cycle tick; returns just after the tick edge.
  task automatic frame(input int n);
    repeat (n) begin
      repeat (3) @(negedge clk);
      frame_tick = 1'b1;
      @(negedge clk);
      frame_tick = 1'b0;
    end
  endtask

  task automatic load(input logic [6:0] v);
    ld_en = 1'b1;
    ld_value = v;
    frame(1);
    ld_en = 1'b0;
  endtask

  initial begin
    int p0;
    int exp_hold[10];
    logic prev_tick;
    exp_hold = '{84, 85, 85, 85, 85, 0, 0, 1, 1, 2};

    repeat (3) @(negedge clk);
    chk("reset_selector", selector, 0);
    chk("reset_changed", changed, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single press, one step one clk after the second tick
    p0 = n_pulse;
    btn_next = 1'b1;
    frame(1); chk("tap_tick1", selector, 0);
    frame(1); chk("tap_tick2", selector, 1); chk("tap_pulse", changed, 1);
    frame(1);
    btn_next = 1'b0;
    frame(3); chk("tap_final", selector, 1);
    chk("tap_pulse_count", n_pulse - p0, 1);

    // hold from 84 through the wrap
    load(7'd84); chk("load_84", selector, 84);
    btn_next = 1'b1;
    for (int i = 0; i < 10; i++) begin
      frame(1);
      chk("hold_repeat", selector, exp_hold[i]);
    end
    btn_next = 1'b0;
    frame(3); chk("hold_release", selector, 2);

    // prev wrap from 0, then next with selector above max
    load(7'd0); chk("load_0", selector, 0);
    btn_prev = 1'b1; frame(2); chk("prev_wrap", selector, 85);
    btn_prev = 1'b0; frame(3);
    max = 7'd40;
    btn_next = 1'b1; frame(2); chk("next_over_max", selector, 0);
    btn_next = 1'b0; frame(3);
    max = 7'd85;

    // auto-cycle and restart after a manual step
    auto_en = 1'b1;
    frame(4); chk("auto_4", selector, 0);
    frame(1); chk("auto_5", selector, 1);
    frame(5); chk("auto_10", selector, 2);
    frame(2);
    btn_prev = 1'b1; frame(2); chk("auto_prev_step", selector, 1);
    btn_prev = 1'b0; frame(2);
    frame(4); chk("auto_restart_4", selector, 1);
    frame(1); chk("auto_restart_5", selector, 2);
    auto_en = 1'b0; frame(1);

    // load outranks a simultaneous button step and clamps to max
    btn_next = 1'b1; frame(1);
    load(7'd100); chk("load_clamp", selector, 85);
    btn_next = 1'b0; frame(3); chk("load_clamp_after", selector, 85);
    p0 = n_pulse;
    load(7'd85); chk("load_same_changed", changed, 0);
    frame(1); chk("load_same_pulses", n_pulse - p0, 0);

    // both buttons cancel; a one-frame glitch does not step
    btn_next = 1'b1; btn_prev = 1'b1;
    frame(2); chk("both_cancel", selector, 85);
    frame(4); chk("both_held", selector, 85);
    btn_next = 1'b0; btn_prev = 1'b0; frame(3);
    btn_next = 1'b1; frame(1); btn_next = 1'b0; frame(3);
    chk("glitch", selector, 85);

    // async reset in REPEAT
    btn_next = 1'b1; frame(7); chk("pre_reset", selector, 1);
    @(negedge clk); #2 rst_n = 1'b0;
    #1 chk("reset_async_sel", selector, 0);
    chk("reset_async_chg", changed, 0);
    btn_next = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    frame(4); chk("reset_no_step", selector, 0);

    // randomized traffic, checked every cycle against the model
    prev_tick = 1'b0;
    for (int c = 0; c < 8000; c++) begin
      @(negedge clk);
      if (ld_en && prev_tick) ld_en = 1'b0;
      frame_tick = ($urandom_range(0, 3) == 0);
      prev_tick = frame_tick;
      if (btn_next ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 79) == 0)) btn_next = ~btn_next;
      if (btn_prev ? ($urandom_range(0, 29) == 0) : ($urandom_range(0, 79) == 0)) btn_prev = ~btn_prev;
      if ($urandom_range(0, 299) == 0) auto_en = ~auto_en;
      if (!ld_en && $urandom_range(0, 79) == 0) begin
        ld_en = 1'b1;
        ld_value = 7'($urandom_range(0, 127));
      end
      if ($urandom_range(0, 199) == 0)
        max = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'd85;
      if ($urandom_range(0, 2999) == 0) begin
        #2 rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        prev_tick = 1'b0;
      end
    end
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/flag_sequencer.md
Name: flag_sequencer

Overview:
- Upstream control stage of the flag selection path.
- Turns two raw push-buttons, an auto-cycle enable and a direct-load request into the 7-bit flag `selector` consumed by the flag lookup stage.
- Wraps the selector against the `max` index reported by that stage.
- Updates only at frame boundaries so a flag never changes mid-frame.

Parameters:
- DEBOUNCE_FRAMES, 2: consecutive equal frame-tick samples needed to accept a new button level.
- REPEAT_DELAY, 30: frames a button must be held before auto-repeat starts.
- REPEAT_RATE, 8: frames between repeated steps while held.
- AUTO_FRAMES, 300: frames per flag in auto-cycle mode (5 s at 60 Hz).

Ports:
- clk  in  1  system clock (single clock domain).
- rst_n  in  1  reset, asynchronous, active-low.
- frame_tick  in  1  one-cycle pulse at start of vertical blanking.
- btn_next  in  1  raw asynchronous button, active-high.
- btn_prev  in  1  raw asynchronous button, active-high.
- auto_en  in  1  raw asynchronous level; 1 = auto-cycle enabled.
- ld_en  in  1  synchronous load strobe, held until the next frame_tick is seen.
- ld_value  in  7  requested selector for a load.
- max  in  7  highest valid selector index (85 today).
- selector  out  7  registered flag index.
- changed  out  1  one-cycle pulse when selector updates.

Behaviour:
- Reset: selector=0, changed=0; all counters, synchronisers, debounced levels and FSMs cleared; button FSMs in IDLE.
- Synchronisation:
  - btn_next, btn_prev and auto_en each pass through a 2-flop synchroniser.
  - ld_en and ld_value are treated as synchronous.
- Debounce (per button, evaluated only on frame_tick):
  - The debounced level flips after DEBOUNCE_FRAMES consecutive samples that differ from the current level.
  - Any agreeing sample clears the count.
- Button FSM (per button, frame_tick-driven):
  - IDLE: on debounced rise, issue a step request, clear the hold counter, go to DELAY.
  - DELAY: hold counter +1 per frame. When it reaches REPEAT_DELAY-1, issue a request, clear the counter, go to REPEAT.
  - REPEAT: when the counter reaches REPEAT_RATE-1, issue a request and clear the counter.
  - Debounced fall in any state returns to IDLE with no request.
- Auto counter:
  - Increments on frame_tick when synced auto_en=1 and both buttons are in IDLE.
  - At AUTO_FRAMES-1 it issues a next request and clears.
  - Cleared whenever auto_en=0, any button is non-IDLE, or any step or load is applied.
- Arbitration, one decision per frame_tick, in priority order:
  1. ld_en: selector = (ld_value > max) ? max : ld_value.
  2. Next and prev requests in the same frame cancel each other; no change and no changed pulse.
  3. A single manual request.
  4. An auto request.
- Step arithmetic:
  - next: selector==max → 0; selector>max → 0; else +1.
  - prev: selector==0 → max; selector>max → max; else −1.
  - All compares are 7-bit unsigned.
- Timing:
  - Selector and changed update on the clk edge after the frame_tick cycle (1-cycle latency).
  - changed=1 only if the new value differs from the old one.
  - A load equal to the current value gives no pulse.
- Without frame_tick, nothing changes: no debounce, no steps, no auto.
- Async reset mid-repeat or mid-auto immediately restores reset values; no step is issued on deassertion.
- Counter widths are $clog2 of their parameter, minimum 1 bit, so they never overflow.

Decomposition:
- Package flag_seq_pkg:
  - SEL_W=7.
  - typedef btn_state_t {IDLE, DELAY, REPEAT}.
  - typedef step_t {STEP_NONE, STEP_NEXT, STEP_PREV, STEP_LOAD}.
- Sub-module flag_btn_repeat:
  - Contains the synchroniser, frame-sampled debounce and repeat FSM.
  - Outputs step_req (pulse on the frame_tick cycle) and active (state != IDLE).
  - Instantiated twice.
- The top level holds the auto counter, arbitration and selector register.

Test Plan (DEBOUNCE_FRAMES=2, REPEAT_DELAY=4, REPEAT_RATE=2, AUTO_FRAMES=5, max=85):
- Reset, then hold btn_next for 3 frame_ticks and release → selector 0→1 exactly once; one changed pulse, one clk after the 2nd tick.
- Hold btn_next for 10 frames from selector=84 → steps 84→85→0→1→2 (initial step, then repeats every 2 frames after the 4-frame delay); wrap 85→0 observed.
- selector=0, tap btn_prev → selector=85. Then drive max=40 and tap btn_next → selector=0.
- auto_en=1, no buttons → selector advances by 1 every 5 frame_ticks. Pressing btn_prev mid-count steps back and restarts the 5-frame count.
- ld_en with ld_value=100 and max=85 at the same frame as a btn_next request → selector=85, load wins. ld_value equal to current → changed stays 0.
- Both buttons debounced-pressed in the same frame → no change. A 1-frame glitch on btn_next → no step. Assert rst_n low during REPEAT → selector=0 immediately, no step after release.
